// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: default geometry, bus widths and FSM state type.
package fb_pkg;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;
   localparam int FB_DEPTH  = 307200;
   localparam int ADDR_W    = 19;
   localparam int COLOR_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAW  = 2'd3
   } fb_state_t;
endpackage

// File: rtl/frame_draw_controller_rect_addr_gen.sv
// Rectangle scan generator: clips a request to the screen, then walks it
// row-major producing one frame-buffer address per step. A full-frame load
// reuses the same walker for buffer clears.
module rect_addr_gen
   import fb_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_full,
   input  logic              load_rect,
   input  logic              step,
   input  logic [9:0]        req_x,
   input  logic [8:0]        req_y,
   input  logic [9:0]        req_w,
   input  logic [8:0]        req_h,
   output logic              empty,
   output logic              last,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [10:0]       H_LIM  = 11'(H_RES);
   localparam logic [9:0]        V_LIM  = 10'(V_RES);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

   logic [10:0]       x_sum, x_end, x_last_clip;
   logic [9:0]        y_sum, y_end, y_last_clip;
   logic [ADDR_W-1:0] req_base;
   logic [ADDR_W-1:0] row_next;

   logic [10:0]       x0, cur_x, x_last;
   logic [9:0]        cur_y, y_last;
   logic [ADDR_W-1:0] row_base;

   // Clip the incoming request; sums are one bit wider than the operands so they never wrap.
   always_comb begin
      x_sum       = {1'b0, req_x} + {1'b0, req_w};
      y_sum       = {1'b0, req_y} + {1'b0, req_h};
      x_end       = (x_sum > H_LIM) ? H_LIM : x_sum;
      y_end       = (y_sum > V_LIM) ? V_LIM : y_sum;
      x_last_clip = x_end - 11'd1;
      y_last_clip = y_end - 10'd1;
      empty       = (req_w == 10'd0) || (req_h == 9'd0) ||
                    ({1'b0, req_x} >= H_LIM) || ({1'b0, req_y} >= V_LIM);
      req_base    = ADDR_W'(req_y) * H_STEP;
      row_next    = row_base + H_STEP;
      last        = (cur_x == x_last) && (cur_y == y_last);
   end

   // Walker registers; the address is held whenever no load or step occurs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0       <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         x_last   <= '0;
         y_last   <= '0;
         row_base <= '0;
         addr     <= '0;
      end else if (load_full) begin
         x0       <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         x_last   <= H_LIM - 11'd1;
         y_last   <= V_LIM - 10'd1;
         row_base <= '0;
         addr     <= '0;
      end else if (load_rect) begin
         x0       <= {1'b0, req_x};
         cur_x    <= {1'b0, req_x};
         cur_y    <= {1'b0, req_y};
         x_last   <= x_last_clip;
         y_last   <= y_last_clip;
         row_base <= req_base;
         addr     <= req_base + ADDR_W'(req_x);
      end else if (step) begin
         if (cur_x == x_last) begin
            cur_x    <= x0;
            cur_y    <= cur_y + 10'd1;
            row_base <= row_next;
            addr     <= row_next + ADDR_W'(x0);
         end else begin
            cur_x <= cur_x + 11'd1;
            addr  <= addr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_draw_controller.sv
// Frame draw controller: clears the frame buffer on frame start and fills
// accepted rectangles one pixel per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset; waits for the first frame_start
//   ST_CLEAR | writing BG_COLOR to every pixel, ascending addresses
//   ST_WAIT  | req_ready high; accepts rectangle requests or frame_start
//   ST_DRAW  | writing the clipped rectangle, row-major
module frame_draw_controller
   import fb_pkg::*;
#(
   parameter int                 H_RES    = H_RES_DEF,
   parameter int                 V_RES    = V_RES_DEF,
   parameter logic [COLOR_W-1:0] BG_COLOR = 5'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               clear_en,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [9:0]         req_x,
   input  logic [8:0]         req_y,
   input  logic [9:0]         req_w,
   input  logic [8:0]         req_h,
   input  logic [COLOR_W-1:0] req_color,
   output logic [ADDR_W-1:0]  fb_write_address,
   output logic [COLOR_W-1:0] fb_data_in,
   output logic               fb_we,
   output logic               busy,
   output logic               frame_overrun
);

   fb_state_t state;
   logic      load_full, load_rect, step;
   logic      rect_empty, gen_last;

   rect_addr_gen #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_full (load_full),
      .load_rect (load_rect),
      .step      (step),
      .req_x     (req_x),
      .req_y     (req_y),
      .req_w     (req_w),
      .req_h     (req_h),
      .empty     (rect_empty),
      .last      (gen_last),
      .addr      (fb_write_address)
   );

   // Walker control: frame_start outranks a simultaneous request in WAIT.
   always_comb begin
      load_full = frame_start && clear_en && ((state == ST_IDLE) || (state == ST_WAIT));
      load_rect = (state == ST_WAIT) && !frame_start && req_valid && !rect_empty;
      step      = ((state == ST_CLEAR) || (state == ST_DRAW)) && !gen_last;
   end

   // Sequencer with registered handshake, write strobe and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         req_ready     <= 1'b0;
         fb_we         <= 1'b0;
         fb_data_in    <= '0;
         busy          <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         frame_overrun <= 1'b0;
         case (state)
            ST_IDLE, ST_WAIT: begin
               if (frame_start) begin
                  if (clear_en) begin
                     state      <= ST_CLEAR;
                     fb_we      <= 1'b1;
                     fb_data_in <= BG_COLOR;
                     busy       <= 1'b1;
                     req_ready  <= 1'b0;
                  end else begin
                     state     <= ST_WAIT;
                     req_ready <= 1'b1;
                  end
               end else if ((state == ST_WAIT) && req_valid && !rect_empty) begin
                  state      <= ST_DRAW;
                  fb_we      <= 1'b1;
                  fb_data_in <= req_color;
                  busy       <= 1'b1;
                  req_ready  <= 1'b0;
               end
            end
            ST_CLEAR, ST_DRAW: begin
               frame_overrun <= frame_start;
               if (gen_last) begin
                  state     <= ST_WAIT;
                  fb_we     <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_draw_controller.sv
// Directed bench for frame_draw_controller on a reduced 64x48 screen.
module tb_frame_draw_controller;
   import fb_pkg::*;

   localparam int         H    = 64;
   localparam int         V    = 48;
   localparam logic [4:0] BG   = 5'd0;
   localparam int         NONE = 100000;

   logic        clk, rst_n;
   logic        frame_start, clear_en, req_valid, req_ready;
   logic [9:0]  req_x, req_w;
   logic [8:0]  req_y, req_h;
   logic [4:0]  req_color, fb_data_in;
   logic [18:0] fb_write_address;
   logic        fb_we, busy, frame_overrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int x, y, w, h, c;
      int cnt, first, last;
   } vec_t;

   vec_t vecs[10];

   frame_draw_controller #(
      .H_RES    (H),
      .V_RES    (V),
      .BG_COLOR (BG)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_start      (frame_start),
      .clear_en         (clear_en),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_x            (req_x),
      .req_y            (req_y),
      .req_w            (req_w),
      .req_h            (req_h),
      .req_color        (req_color),
      .fb_write_address (fb_write_address),
      .fb_data_in       (fb_data_in),
      .fb_we            (fb_we),
      .busy             (busy),
      .frame_overrun    (frame_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Collect a rectangle's writes starting at the negedge after acceptance.
   task automatic collect_rect(input vec_t v, input int fs_at);
      int q[$];
      int n, first_a, last_a, xe, ye;
      xe = (v.x + v.w > H) ? H : v.x + v.w;
      ye = (v.y + v.h > V) ? V : v.y + v.h;
      for (int yy = v.y; yy < ye; yy++)
         for (int xx = v.x; xx < xe; xx++)
            q.push_back(yy * H + xx);
      n = 0; first_a = -1; last_a = -1;
      while (fb_we === 1'b1 && n < 4000) begin
         if (n == 0) first_a = int'(fb_write_address);
         last_a = int'(fb_write_address);
         if (n < q.size()) check("rect_addr", fb_write_address, q[n]);
         check("rect_data", fb_data_in, v.c);
         if (n == 0) check("busy_draw", busy, 1);
         if (n == fs_at) begin frame_start = 1'b1; clear_en = 1'b1; end
         if (n == fs_at + 1) begin
            frame_start = 1'b0; clear_en = 1'b0;
            check("overrun_pulse", frame_overrun, 1);
         end
         if (n == fs_at + 2) check("overrun_clear", frame_overrun, 0);
         n++;
         @(negedge clk);
      end
      check("rect_count", n, v.cnt);
      if (v.cnt > 0) begin
         check("rect_first", first_a, v.first);
         check("rect_last", last_a, v.last);
      end
      check("ready_after", req_ready, 1);
      check("busy_after", busy, 0);
   endtask

   task automatic run_req(input vec_t v, input int fs_at);
      check("ready_before", req_ready, 1);
      req_x = 10'(v.x); req_y = 9'(v.y); req_w = 10'(v.w); req_h = 9'(v.h);
      req_color = 5'(v.c);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      collect_rect(v, fs_at);
   endtask

   task automatic start_clear();
      frame_start = 1'b1; clear_en = 1'b1;
      @(negedge clk);
      frame_start = 1'b0; clear_en = 1'b0;
   endtask

   task automatic collect_clear();
      int n;
      n = 0;
      check("busy_clear", busy, 1);
      while (fb_we === 1'b1 && n < H * V + 10) begin
         check("clear_addr", fb_write_address, n);
         check("clear_data", fb_data_in, BG);
         n++;
         @(negedge clk);
      end
      check("clear_count", n, H * V);
      check("ready_after_clear", req_ready, 1);
   endtask

   initial begin
      int n, wr;
      vecs[0] = '{10, 5, 3, 2, 7, 6, 330, 396};
      vecs[1] = '{62, 47, 5, 4, 3, 2, 3070, 3071};
      vecs[2] = '{0, 0, 0, 5, 4, 0, 0, 0};
      vecs[3] = '{64, 0, 4, 4, 9, 0, 0, 0};
      vecs[4] = '{5, 48, 2, 2, 1, 0, 0, 0};
      vecs[5] = '{0, 0, 1, 1, 31, 1, 0, 0};
      vecs[6] = '{60, 46, 1023, 511, 12, 8, 3004, 3071};
      vecs[7] = '{0, 10, 64, 1, 5, 64, 640, 703};
      vecs[8] = '{3, 0, 2, 3, 1, 6, 3, 132};
      vecs[9] = '{1000, 0, 1000, 1, 2, 0, 0, 0};

      frame_start = 0; clear_en = 0; req_valid = 0;
      req_x = 0; req_y = 0; req_w = 0; req_h = 0; req_color = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      check("rst_ready", req_ready, 0);
      check("rst_we", fb_we, 0);
      check("rst_addr", fb_write_address, 0);
      check("rst_data", fb_data_in, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", frame_overrun, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      wr = 0;
      repeat (5) begin
         @(negedge clk);
         if (fb_we !== 1'b0 || req_ready !== 1'b0) wr++;
      end
      check("idle_quiet", wr, 0);

      start_clear();
      collect_clear();

      for (int i = 0; i < 10; i++) run_req(vecs[i], NONE);

      begin
         vec_t d;
         d = '{0, 20, 64, 2, 6, 128, 1280, 1407};
         run_req(d, 5);
      end

      req_x = 10; req_y = 5; req_w = 3; req_h = 2; req_color = 7;
      req_valid = 1'b1;
      start_clear();
      collect_clear();
      @(negedge clk);
      req_valid = 1'b0;
      collect_rect(vecs[0], NONE);

      start_clear();
      n = 0;
      while (fb_write_address !== 19'd1000 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_1000", fb_write_address, 1000);
      check("we_before_rst", fb_we, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", fb_we, 0);
      check("midrst_addr", fb_write_address, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wr = 0;
      repeat (20) begin
         @(negedge clk);
         if (fb_we !== 1'b0 || req_ready !== 1'b0) wr++;
      end
      check("post_rst_quiet", wr, 0);

      frame_start = 1'b1; clear_en = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;
      check("noclear_ready", req_ready, 1);
      check("noclear_we", fb_we, 0);
      run_req(vecs[1], NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
